store_align_unit: RTL and testbench

Store-side counterpart of the load sign/zero-extension path. It accepts store requests from the execute/memory stage (address, rs2 data, funct3) and converts each one to a word-aligned address, lane-replicated write data and a 4-bit byte-write mask. Legal stores are queued in a small store buffer and drained to data memory over a req/ack handshake. Misaligned or illegal stores are rejected and flagged.

---
 rtl/store_align_unit_if.sv | 36 +++
 rtl/store_align_unit.sv | 161 ++++++++++++++++
 tb/tb_store_align_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/store_align_unit_if.sv
// Store request / data-memory drain bundle for store_align_unit.
// The unit sits on the slave modport; the store source and memory model use master.
interface store_align_unit_if #(
  parameter int DEPTH = 2
);
  // Store request side
  logic                      st_valid;
  logic                      st_ready;
  logic [31:0]               st_addr;
  logic [31:0]               st_data;
  logic [2:0]                funct3;
  logic                      misalign;

  // Data-memory drain side
  logic                      dmem_req;
  logic                      dmem_ack;
  logic [31:0]               dmem_addr;
  logic [31:0]               dmem_wdata;
  logic [3:0]                dmem_mask;

  // Status
  logic                      empty;
  logic [$clog2(DEPTH):0]    count;

  modport slave (
    input  st_valid, st_addr, st_data, funct3, dmem_ack,
    output st_ready, misalign, dmem_req, dmem_addr, dmem_wdata, dmem_mask,
           empty, count
  );

  modport master (
    output st_valid, st_addr, st_data, funct3, dmem_ack,
    input  st_ready, misalign, dmem_req, dmem_addr, dmem_wdata, dmem_mask,
           empty, count
  );
endinterface

// File: rtl/store_align_unit.sv
// Store alignment and buffering: formats SB/SH/SW requests into a word address,
// lane-replicated data and a byte mask, queues legal stores in a circular FIFO
// and drains them in order over a req/ack handshake. Illegal or misaligned
// stores are consumed and flagged with a one-cycle misalign pulse.
module store_align_unit #(
  parameter int DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  store_align_unit_if.slave  st_if
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Legality: halfwords need off[0]==0, words need off==0, other funct3 illegal.
  function automatic logic is_legal(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3)
      F3_SB:   ok = 1'b1;
      F3_SH:   ok = (off[0] == 1'b0);
      F3_SW:   ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte-write mask for a store of the given size at the given byte offset.
  function automatic logic [3:0] fmt_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3)
      F3_SB:   m = 4'b0001 << off;
      F3_SH:   m = off[1] ? 4'b1100 : 4'b0011;
      F3_SW:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Write data replicated across every lane the store could target.
  function automatic logic [31:0] fmt_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      F3_SB:   w = {4{d[7:0]}};
      F3_SH:   w = {2{d[15:0]}};
      F3_SW:   w = d;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // Buffer state
  logic [29:0]   addr_q  [DEPTH];
  logic [31:0]   wdata_q [DEPTH];
  logic [3:0]    mask_q  [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          misalign_q, misalign_d;

  // Decoded request / drain events
  logic          full_s;
  logic          empty_s;
  logic          accept_s;
  logic          legal_s;
  logic          push_s;
  logic          pop_s;

  assign full_s   = (count_q == CW'(DEPTH));
  assign empty_s  = (count_q == {CW{1'b0}});
  assign accept_s = st_if.st_valid && !full_s;
  assign legal_s  = is_legal(st_if.funct3, st_if.st_addr[1:0]);
  assign push_s   = accept_s && legal_s;
  assign pop_s    = !empty_s && st_if.dmem_ack;

  // Next-state for pointers, occupancy and the misalign pulse.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    misalign_d = accept_s && !legal_s;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Simultaneous push and pop leaves occupancy unchanged.
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Control state registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      misalign_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // Entry storage: formatted store written at the tail on push.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= 30'h0000_0000;
        wdata_q[i] <= 32'h0000_0000;
        mask_q[i]  <= 4'b0000;
      end
    end else if (push_s) begin
      addr_q[wr_ptr_q]  <= st_if.st_addr[31:2];
      wdata_q[wr_ptr_q] <= fmt_wdata(st_if.funct3, st_if.st_data);
      mask_q[wr_ptr_q]  <= fmt_mask(st_if.funct3, st_if.st_addr[1:0]);
    end
  end

  // Head entry drive; forced to zero whenever the buffer is empty.
  always_comb begin
    st_if.dmem_addr  = 32'h0000_0000;
    st_if.dmem_wdata = 32'h0000_0000;
    st_if.dmem_mask  = 4'b0000;
    if (!empty_s) begin
      st_if.dmem_addr  = {addr_q[rd_ptr_q], 2'b00};
      st_if.dmem_wdata = wdata_q[rd_ptr_q];
      st_if.dmem_mask  = mask_q[rd_ptr_q];
    end else begin
      st_if.dmem_addr  = 32'h0000_0000;
      st_if.dmem_wdata = 32'h0000_0000;
      st_if.dmem_mask  = 4'b0000;
    end
  end

  assign st_if.st_ready = !full_s;
  assign st_if.dmem_req = !empty_s;
  assign st_if.empty    = empty_s;
  assign st_if.count    = count_q;
  assign st_if.misalign = misalign_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit (DEPTH=2): formatting, rejection,
// full-buffer back-pressure, push/pop overlap, async reset and stray ack.
module tb_store_align_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  store_align_unit_if #(.DEPTH(2)) st_if ();

  store_align_unit #(.DEPTH(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .st_if   (st_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic ack);
    st_if.st_valid = v;
    st_if.funct3   = f3;
    st_if.st_addr  = a;
    st_if.st_data  = d;
    st_if.dmem_ack = ack;
  endtask

  task automatic head(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m);
    check_eq({tag, "_addr"},  st_if.dmem_addr,  a);
    check_eq({tag, "_wdata"}, st_if.dmem_wdata, d);
    check_eq({tag, "_mask"},  {28'h0, st_if.dmem_mask}, {28'h0, m});
  endtask

  task automatic idle_state(input string tag);
    check_eq({tag, "_req"},   {31'h0, st_if.dmem_req}, 32'd0);
    check_eq({tag, "_empty"}, {31'h0, st_if.empty},    32'd1);
    check_eq({tag, "_count"}, {30'h0, st_if.count},    32'd0);
    check_eq({tag, "_ready"}, {31'h0, st_if.st_ready}, 32'd1);
    check_eq({tag, "_mis"},   {31'h0, st_if.misalign}, 32'd0);
    head(tag, 32'h0, 32'h0, 4'b0000);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_state("reset");

    // SB at offset 3, ack low
    drive(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 1'b0);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    check_eq("sb_req",   {31'h0, st_if.dmem_req}, 32'd1);
    check_eq("sb_count", {30'h0, st_if.count},    32'd1);
    head("sb", 32'h0000_1000, 32'hABAB_ABAB, 4'b1000);
    st_if.dmem_ack = 1'b1;
    @(negedge clk);
    st_if.dmem_ack = 1'b0;
    idle_state("sb_drained");

    // SH then SW with ack high; second accept overlaps the first pop
    drive(1'b1, 3'b001, 32'h0000_2002, 32'h1234_CAFE, 1'b1);
    @(negedge clk);
    check_eq("sh_count", {30'h0, st_if.count}, 32'd1);
    head("sh", 32'h0000_2000, 32'hCAFE_CAFE, 4'b1100);
    drive(1'b1, 3'b010, 32'h0000_2004, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    check_eq("pushpop_count", {30'h0, st_if.count}, 32'd1);
    head("sw", 32'h0000_2004, 32'hDEAD_BEEF, 4'b1111);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    st_if.dmem_ack = 1'b0;
    check_eq("shsw_drained", {30'h0, st_if.count}, 32'd0);

    // Back-to-back rejections
    drive(1'b1, 3'b001, 32'h0000_3001, 32'h1111_1111, 1'b0);
    @(negedge clk);
    check_eq("rej_sh_mis", {31'h0, st_if.misalign}, 32'd1);
    check_eq("rej_sh_cnt", {30'h0, st_if.count},    32'd0);
    drive(1'b1, 3'b010, 32'h0000_3002, 32'h2222_2222, 1'b0);
    @(negedge clk);
    check_eq("rej_sw_mis", {31'h0, st_if.misalign}, 32'd1);
    check_eq("rej_sw_req", {31'h0, st_if.dmem_req}, 32'd0);
    drive(1'b1, 3'b011, 32'h0000_3000, 32'h3333_3333, 1'b0);
    @(negedge clk);
    check_eq("rej_f3_mis", {31'h0, st_if.misalign}, 32'd1);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    idle_state("rej_after");

    // Full buffer: three SW with ack low
    drive(1'b1, 3'b010, 32'h0000_4000, 32'h1111_1111, 1'b0);
    @(negedge clk);
    check_eq("full_c1",  {30'h0, st_if.count},    32'd1);
    check_eq("full_r1",  {31'h0, st_if.st_ready}, 32'd1);
    drive(1'b1, 3'b010, 32'h0000_4004, 32'h2222_2222, 1'b0);
    @(negedge clk);
    check_eq("full_c2",  {30'h0, st_if.count},    32'd2);
    check_eq("full_r2",  {31'h0, st_if.st_ready}, 32'd0);
    drive(1'b1, 3'b010, 32'h0000_4008, 32'h3333_3333, 1'b0);
    @(negedge clk);
    check_eq("full_held_c", {30'h0, st_if.count}, 32'd2);
    head("full_head1", 32'h0000_4000, 32'h1111_1111, 4'b1111);
    st_if.dmem_ack = 1'b1;
    @(negedge clk);
    st_if.dmem_ack = 1'b0;
    check_eq("full_pop_c", {30'h0, st_if.count},    32'd1);
    check_eq("full_pop_r", {31'h0, st_if.st_ready}, 32'd1);
    head("full_head2", 32'h0000_4004, 32'h2222_2222, 4'b1111);
    @(negedge clk);
    st_if.st_valid = 1'b0;
    check_eq("full_third_c", {30'h0, st_if.count}, 32'd2);
    st_if.dmem_ack = 1'b1;
    @(negedge clk);
    head("full_head3", 32'h0000_4008, 32'h3333_3333, 4'b1111);
    @(negedge clk);
    st_if.dmem_ack = 1'b0;
    check_eq("full_drained", {30'h0, st_if.count}, 32'd0);

    // Fill with SB at offset 1 and SH at offset 0, then reset mid-cycle
    drive(1'b1, 3'b000, 32'h0000_5001, 32'hFFFF_FF77, 1'b0);
    @(negedge clk);
    drive(1'b1, 3'b001, 32'h0000_5000, 32'h0000_BEEF, 1'b0);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    check_eq("rst_pre_c", {30'h0, st_if.count}, 32'd2);
    head("sb_off1", 32'h0000_5000, 32'h7777_7777, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    idle_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Stray ack while empty
    st_if.dmem_ack = 1'b1;
    @(negedge clk);
    st_if.dmem_ack = 1'b0;
    idle_state("stray_ack");

    // SH at offset 0 after reset
    drive(1'b1, 3'b001, 32'h0000_6000, 32'h0000_BEEF, 1'b0);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    head("sh_off0", 32'h0000_6000, 32'hBEEF_BEEF, 4'b0011);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
